// File: rtl/pixel_sink_packer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink_packer
// Brief    : Shift/clamp pixels to bytes, pack 4 per word, FWFT FIFO out.
//            Define PIXEL_SINK_FRAME_SUM_EN to build the per-frame byte sum.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sink_packer #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] in_pixel,
  input  logic [3:0]  shift,
  input  logic        sat_en,
  input  logic        clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        frame_done,
  output logic [15:0] overflow_cnt,
  output logic [15:0] frame_sum
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW       = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PCW-1:0] LAST_PIX = PCW'(FRAME_PIX - 1);
  localparam logic [AW:0]    DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  logic signed [31:0] shifted;
  logic [7:0]         byte_d;
  logic [7:0]         s1_byte_q;
  logic               s1_valid_q;

  logic [1:0]         lane_q, lane_d;
  logic [PCW-1:0]     pix_q, pix_d;
  logic [31:0]        word_q, word_d, word_full;
  logic               pix_last, word_done;

  logic [32:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               pop, push;
  logic               frame_done_q;
  logic [15:0]        ovf_q;

  assign shifted = $signed(in_pixel) >>> shift;

  always_comb begin
    byte_d = shifted[7:0];
    if (sat_en && shifted[31]) begin
      byte_d = 8'h00;
    end else if (sat_en && (shifted > 32'sd255)) begin
      byte_d = 8'hFF;
    end
  end

  assign pix_last  = (pix_q == LAST_PIX);
  assign word_done = s1_valid_q && ((lane_q == 2'd3) || pix_last);
  assign word_full = word_q | ({24'd0, s1_byte_q} << {lane_q, 3'b000});

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push      = word_done && ((cnt_q < DEPTH_C) || pop);

  always_comb begin
    lane_d = lane_q;
    pix_d  = pix_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    if (s1_valid_q) begin
      if (word_done) begin
        lane_d = 2'd0;
        word_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        word_d = word_full;
      end
      pix_d = pix_last ? '0 : pix_q + PCW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q   <= 1'b0;
      s1_byte_q    <= 8'd0;
      lane_q       <= 2'd0;
      pix_q        <= '0;
      word_q       <= 32'd0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 16'd0;
    end else if (clr) begin
      s1_valid_q   <= 1'b0;
      s1_byte_q    <= 8'd0;
      lane_q       <= 2'd0;
      pix_q        <= '0;
      word_q       <= 32'd0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 16'd0;
    end else begin
      s1_valid_q   <= in_valid;
      if (in_valid) begin
        s1_byte_q <= byte_d;
      end
      lane_q       <= lane_d;
      pix_q        <= pix_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      frame_done_q <= word_done && pix_last;
      if (word_done && !push && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_q] <= {pix_last, word_full};
    end
  end

  // Gate the head so an empty FIFO shows zeros rather than stale entries
  assign out_data     = out_valid ? mem_q[rd_q][31:0] : 32'd0;
  assign out_last     = out_valid & mem_q[rd_q][32];
  assign frame_done   = frame_done_q;
  assign overflow_cnt = ovf_q;

`ifdef PIXEL_SINK_FRAME_SUM_EN
  logic [15:0] acc_q, fsum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= 16'd0;
      fsum_q <= 16'd0;
    end else if (clr) begin
      acc_q  <= 16'd0;
      fsum_q <= 16'd0;
    end else if (s1_valid_q) begin
      if (pix_last) begin
        fsum_q <= acc_q + {8'd0, s1_byte_q};
        acc_q  <= 16'd0;
      end else begin
        acc_q  <= acc_q + {8'd0, s1_byte_q};
      end
    end
  end

  assign frame_sum = fsum_q;
`else
  assign frame_sum = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sink_packer
// Brief    : Directed + random stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sink_packer;

  localparam int IMG_WIDTH  = 3;
  localparam int IMG_HEIGHT = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_PIX  = IMG_WIDTH * IMG_HEIGHT;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pixel = 32'd0;
  logic [3:0]  shift = 4'd0;
  logic        sat_en = 1'b0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, frame_done;
  logic [31:0] out_data;
  logic [15:0] overflow_cnt, frame_sum;

  int checks = 0;
  int errors = 0;

  pixel_sink_packer #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .shift       (shift),
    .sat_en      (sat_en),
    .clr         (clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .overflow_cnt(overflow_cnt),
    .frame_sum   (frame_sum)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          pend_v;
  logic [7:0]  pend_b;
  logic [7:0]  cur_bytes[$];
  int          pix_idx;
  logic [32:0] mq[$];
  int          ovf;
  bit          fdone;
  int          acc;
  int          fsum;
  logic [32:0] popped[$];

  function automatic logic [7:0] byte_of(input logic [31:0] p, input logic [3:0] sh, input logic sat);
    longint s;
    s = longint'(int'(p));
    for (int i = 0; i < int'(sh); i++) begin
      if (s < 0 && (s % 2) != 0) s = (s - 1) / 2;
      else                       s = s / 2;
    end
    if (sat) begin
      if (s < 0)   return 8'd0;
      if (s > 255) return 8'd255;
      return 8'(s);
    end
    return 8'(((s % 256) + 256) % 256);
  endfunction

  function automatic void model_reset();
    pend_v  = 1'b0;
    pend_b  = 8'd0;
    cur_bytes.delete();
    pix_idx = 0;
    mq.delete();
    ovf     = 0;
    fdone   = 1'b0;
    acc     = 0;
    fsum    = 0;
  endfunction

  function automatic void model_edge(input logic v, input logic [31:0] pix, input logic [3:0] sh,
                                     input logic sat, input logic rdy, input logic c);
    bit          pop, last, do_push;
    logic [31:0] word;
    logic [32:0] entry;
    if (c) begin
      model_reset();
      return;
    end
    pop     = (mq.size() > 0) && rdy;
    do_push = 1'b0;
    entry   = '0;
    fdone   = 1'b0;
    if (pend_v) begin
      last = (pix_idx == FRAME_PIX - 1);
      cur_bytes.push_back(pend_b);
      acc = (acc + int'(pend_b)) % 65536;
      if (cur_bytes.size() == 4 || last) begin
        word = 32'd0;
        foreach (cur_bytes[i]) word = word + (32'(cur_bytes[i]) << (8 * i));
        entry = {last, word};
        if (mq.size() < FIFO_DEPTH || pop) do_push = 1'b1;
        else if (ovf < 65535)              ovf++;
        cur_bytes.delete();
      end
      if (last) begin
        fdone = 1'b1;
        fsum  = acc;
        acc   = 0;
      end
      pix_idx = last ? 0 : pix_idx + 1;
    end
    if (pop)     void'(mq.pop_front());
    if (do_push) mq.push_back(entry);
    pend_v = v;
    pend_b = byte_of(pix, sh, sat);
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [32:0] head;
    int          exp_fsum;
    head = (mq.size() > 0) ? mq[0] : 33'd0;
`ifdef PIXEL_SINK_FRAME_SUM_EN
    exp_fsum = fsum;
`else
    exp_fsum = 0;
`endif
    check("out_valid",    33'(out_valid),    33'(mq.size() > 0));
    check("out_data",     33'(out_data),     33'(head[31:0]));
    check("out_last",     33'(out_last),     33'(head[32]));
    check("frame_done",   33'(frame_done),   33'(fdone));
    check("overflow_cnt", 33'(overflow_cnt), 33'(ovf));
    check("frame_sum",    33'(frame_sum),    33'(exp_fsum));
  endtask

  task automatic step(input logic v, input logic [31:0] pix, input logic [3:0] sh,
                      input logic sat, input logic rdy, input logic c);
    in_valid  = v;
    in_pixel  = pix;
    shift     = sh;
    sat_en    = sat;
    out_ready = rdy;
    clr       = c;
    if (out_valid && out_ready && !clr) popped.push_back({out_last, out_data});
    @(posedge clk);
    model_edge(v, pix, sh, sat, rdy, c);
    #1;
    compare_all();
  endtask

  task automatic pixel(input logic [31:0] p, input logic [3:0] sh, input logic sat, input logic rdy);
    step(1'b1, p, sh, sat, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_clr();
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    check("rst_out_valid",    33'(out_valid),    33'd0);
    check("rst_out_data",     33'(out_data),     33'd0);
    check("rst_out_last",     33'(out_last),     33'd0);
    check("rst_frame_done",   33'(frame_done),   33'd0);
    check("rst_overflow_cnt", 33'(overflow_cnt), 33'd0);
    check("rst_frame_sum",    33'(frame_sum),    33'd0);
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] p;
    #2;
    do_reset();

    // 1: four bytes packed LSB-first
    do_clr();
    pixel(32'h10, 4'd0, 1'b1, 1'b0);
    pixel(32'h20, 4'd0, 1'b1, 1'b0);
    pixel(32'h30, 4'd0, 1'b1, 1'b0);
    pixel(32'h40, 4'd0, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("t1_word", 33'(out_data), 33'h040302010);
    check("t1_last", 33'(out_last), 33'd0);

    // 2: clamp and shift, then raw low byte
    do_clr();
    pixel(-32'sd5,  4'd0, 1'b1, 1'b0);
    pixel(32'd300,  4'd0, 1'b1, 1'b0);
    pixel(32'd1000, 4'd2, 1'b1, 1'b0);
    pixel(32'd77,   4'd0, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("t2_clamp_word", 33'(out_data), 33'h04DFAFF00);
    idle(1'b1, 1);
    pixel(32'd300, 4'd0, 1'b0, 1'b0);
    pixel(32'd0,   4'd0, 1'b0, 1'b0);
    pixel(32'd0,   4'd0, 1'b0, 1'b0);
    pixel(32'd0,   4'd0, 1'b0, 1'b0);
    idle(1'b0, 2);
    check("t2_raw_byte", 33'(out_data), 33'h00000002C);

    // 3: full 3x3 frame with a partial final word
    do_clr();
    popped.delete();
    for (int i = 1; i <= 9; i++) pixel(32'(i), 4'd0, 1'b1, 1'b1);
    idle(1'b1, 4);
    check("t3_npop", 33'(popped.size()), 33'd3);
    if (popped.size() >= 3) begin
      check("t3_w0", popped[0], {1'b0, 32'h04030201});
      check("t3_w1", popped[1], {1'b0, 32'h08070605});
      check("t3_w2", popped[2], {1'b1, 32'h00000009});
    end
`ifdef PIXEL_SINK_FRAME_SUM_EN
    check("t3_frame_sum", 33'(frame_sum), 33'd45);
`endif

    // 4: overflow with consumer stalled, then drain
    do_clr();
    for (int i = 1; i <= 20; i++) pixel(32'(i), 4'd0, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("t4_overflow", 33'(overflow_cnt), 33'd2);
    popped.delete();
    idle(1'b1, 6);
    check("t4_npop", 33'(popped.size()), 33'd4);
    if (popped.size() >= 4) begin
      check("t4_w0", popped[0], {1'b0, 32'h04030201});
      check("t4_w1", popped[1], {1'b0, 32'h08070605});
      check("t4_w2", popped[2], {1'b1, 32'h00000009});
      check("t4_w3", popped[3], {1'b0, 32'h0D0C0B0A});
    end

    // 5: clear mid-word restarts lane and pixel count
    pixel(32'hAA, 4'd0, 1'b1, 1'b0);
    pixel(32'hBB, 4'd0, 1'b1, 1'b0);
    do_clr();
    for (int i = 1; i <= 4; i++) pixel(32'(i), 4'd0, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("t5_word", {out_last, out_data}, {1'b0, 32'h04030201});
    check("t5_overflow", 33'(overflow_cnt), 33'd0);
    for (int i = 5; i <= 9; i++) pixel(32'(i), 4'd0, 1'b1, 1'b1);
    idle(1'b1, 4);

    // 6: asynchronous reset with words queued, then a clean frame
    do_clr();
    for (int i = 0; i < 11; i++) pixel($urandom_range(0, 255), 4'd0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < FRAME_PIX; i++) pixel($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    idle(1'b1, 4);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       p = $urandom_range(0, 255);
        1:       p = $urandom_range(256, 5000);
        2:       p = -$urandom_range(1, 5000);
        default: p = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, p, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
